// File: rtl/pad_report_reader.sv
// NES-style serial gamepad poller: latches the pad, shifts in eight active-low bits and
// publishes a registered active-high report. Define PAD_DEBOUNCE_EN to require two matching frames.
module pad_report_reader #(
  parameter int unsigned POLL_DIV = 833333,
  parameter int unsigned HALF_BIT = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] controller_report,
  output logic [7:0] press_edge,
  output logic       report_valid
);

  localparam int unsigned PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int unsigned CW = $clog2(2 * HALF_BIT);

  typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   poll_cnt;
  logic [CW-1:0]   ph_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      raw;
  logic [7:0]      new_report;
  logic            data_meta, data_sync;
  logic            tick;
  logic            ph_clr, bit_clr, bit_inc, capture, frame_end;

  assign tick = (poll_cnt == PW'(POLL_DIV - 1));

  // Serial order A,B,Sel,Start,Up,Down,Left,Right -> report order swaps Start and Up.
  assign new_report = ~{raw[7], raw[6], raw[5], raw[3], raw[4], raw[2], raw[1], raw[0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      data_meta <= pad_data;
      data_sync <= data_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) poll_cnt <= '0;
    else if (tick) poll_cnt <= '0;
    else poll_cnt <= poll_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end

  always_comb begin
    state_n   = state;
    ph_clr    = 1'b0;
    bit_clr   = 1'b0;
    bit_inc   = 1'b0;
    capture   = 1'b0;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          state_n = LATCH;
          ph_clr  = 1'b1;
          bit_clr = 1'b1;
        end
      end
      LATCH: begin
        if (ph_cnt == CW'(2 * HALF_BIT - 1)) begin
          state_n = LOW;
          ph_clr  = 1'b1;
        end
      end
      LOW: begin
        if (ph_cnt == CW'(HALF_BIT - 1)) begin
          capture = 1'b1;
          ph_clr  = 1'b1;
          state_n = (bit_idx == 3'd7) ? DONE : HIGH;
        end
      end
      HIGH: begin
        if (ph_cnt == CW'(HALF_BIT - 1)) begin
          bit_inc = 1'b1;
          ph_clr  = 1'b1;
          state_n = LOW;
        end
      end
      DONE: begin
        frame_end = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph_cnt  <= '0;
      bit_idx <= '0;
      raw     <= '1;
    end else begin
      if (ph_clr) ph_cnt <= '0;
      else if (state != IDLE) ph_cnt <= ph_cnt + 1'b1;
      if (bit_clr) bit_idx <= '0;
      else if (bit_inc) bit_idx <= bit_idx + 1'b1;
      if (capture) raw[bit_idx] <= data_sync;
    end
  end

  // Pad lines are registered from the next state so they toggle glitch-free on the state edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pad_latch <= 1'b0;
      pad_clk   <= 1'b1;
    end else begin
      pad_latch <= (state_n == LATCH);
      pad_clk   <= (state_n != LOW);
    end
  end

`ifdef PAD_DEBOUNCE_EN
  logic [7:0] prev_raw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      controller_report <= '0;
      press_edge        <= '0;
      report_valid      <= 1'b0;
      prev_raw          <= '1;
    end else begin
      press_edge   <= '0;
      report_valid <= frame_end;
      if (frame_end) begin
        prev_raw <= raw;
        if (raw == prev_raw) begin
          controller_report <= new_report;
          press_edge        <= new_report & ~controller_report;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      controller_report <= '0;
      press_edge        <= '0;
      report_valid      <= 1'b0;
    end else begin
      press_edge   <= '0;
      report_valid <= frame_end;
      if (frame_end) begin
        controller_report <= new_report;
        press_edge        <= new_report & ~controller_report;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pad_report_reader.sv
// Directed bench for pad_report_reader with a behavioural NES pad and an expected-report queue.
module tb_pad_report_reader;

  localparam int H  = 300;
  localparam int PD = 5200;

  logic       clk = 1'b0;
  logic       reset;
  logic       pad_data;
  logic       pad_latch, pad_clk;
  logic [7:0] controller_report, press_edge;
  logic       report_valid;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [7:0] rep;
    logic [7:0] edg;
  } exp_t;
  exp_t q[$];

  logic [7:0] m_rep;
  logic [7:0] m_prev;
  logic [7:0] pad_pressed;
  logic [3:0] pad_idx = 4'd8;

  pad_report_reader #(.POLL_DIV(PD), .HALF_BIT(H)) dut (
    .clk(clk), .reset(reset), .pad_data(pad_data),
    .pad_latch(pad_latch), .pad_clk(pad_clk),
    .controller_report(controller_report), .press_edge(press_edge),
    .report_valid(report_valid)
  );

  always #5 clk = ~clk;

  // Pad: latch loads bit 0, each rising pad_clk presents the next bit; unused slots read high.
  always @(posedge pad_latch or posedge pad_clk) begin
    if (pad_latch) pad_idx = 4'd0;
    else if (pad_idx < 4'd8) pad_idx = pad_idx + 4'd1;
  end
  assign pad_data = (pad_idx < 4'd8) ? ~pad_pressed[pad_idx[2:0]] : 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_report(input logic [7:0] s);
    return {s[7], s[6], s[5], s[3], s[4], s[2], s[1], s[0]};
  endfunction

  task automatic push_expected(input logic [7:0] s);
    logic [7:0] nr, ed, rw;
    rw = ~s;
    nr = to_report(s);
`ifdef PAD_DEBOUNCE_EN
    if (rw == m_prev) begin
      ed    = nr & ~m_rep;
      m_rep = nr;
    end else ed = 8'h00;
    m_prev = rw;
`else
    ed    = nr & ~m_rep;
    m_rep = nr;
`endif
    q.push_back('{rep: m_rep, edg: ed});
  endtask

  task automatic model_reset();
    m_rep  = 8'h00;
    m_prev = 8'hFF;
    q.delete();
  endtask

  task automatic wait_latch(output int n);
    n = 0;
    while (n < PD + 20) begin
      @(negedge clk);
      n++;
      if (pad_latch) return;
    end
    chk("latch_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_frame(input logic [7:0] s, input bit chk_delay);
    int n, valid_at, latch_hi, falls, lows;
    logic prev_clk;
    logic early;
    logic [7:0] rep0;
    exp_t e;
    pad_pressed = s;
    push_expected(s);
    e = '0;
    wait_latch(n);
    if (chk_delay) chk("latch_delay", n, PD);
    valid_at = -1; latch_hi = 0; falls = 0; lows = 0;
    prev_clk = 1'b1; early = 1'b0; rep0 = controller_report;
    for (int c = 0; c <= 17 * H + 1; c++) begin
      if (c > 0) @(negedge clk);
      if (pad_latch) latch_hi++;
      if (!pad_clk) lows++;
      if (prev_clk && !pad_clk) falls++;
      prev_clk = pad_clk;
      if (report_valid && valid_at < 0) begin
        valid_at = c;
        e = q.pop_front();
        chk("report", controller_report, e.rep);
        chk("press_edge", press_edge, e.edg);
      end else if (valid_at < 0 && controller_report !== rep0) early = 1'b1;
    end
    if (valid_at < 0 && q.size() > 0) e = q.pop_front();
    chk("valid_cycle", valid_at, 17 * H + 1);
    chk("latch_width", latch_hi, 2 * H);
    chk("clk_low_pulses", falls, 8);
    chk("clk_low_cycles", lows, 8 * H);
    chk("report_stable", early, 1'b0);
    @(negedge clk);
    chk("edge_clear", press_edge, 8'h00);
    chk("valid_clear", report_valid, 1'b0);
    chk("report_hold", controller_report, e.rep);
  endtask

  initial begin
    int n;
    model_reset();
    pad_pressed = 8'h00;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_report", controller_report, 8'h00);
    chk("rst_edge", press_edge, 8'h00);
    chk("rst_valid", report_valid, 1'b0);
    chk("rst_latch", pad_latch, 1'b0);
    chk("rst_clk", pad_clk, 1'b1);
    #1 reset = 1'b0;

    run_frame(8'h00, 1'b1);   // idle pad
    run_frame(8'h09, 1'b0);   // A + Start
    run_frame(8'h09, 1'b0);   // held
    run_frame(8'h19, 1'b0);   // A + Start + Up

    // Reset in the LOW phase of serial bit 4.
    pad_pressed = 8'h19;
    wait_latch(n);
    repeat (10 * H + 100) @(negedge clk);
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_latch", pad_latch, 1'b0);
    chk("mid_rst_clk", pad_clk, 1'b1);
    chk("mid_rst_report", controller_report, 8'h00);
    chk("mid_rst_edge", press_edge, 8'h00);
    chk("mid_rst_valid", report_valid, 1'b0);
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;

    run_frame(8'h00, 1'b1);   // all released, latch delay after reset
    run_frame(8'h10, 1'b0);   // single-frame Up glitch
    run_frame(8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
